// File: rtl/looped_iir_pkg.sv
// ----------------------------------------------------------------------------
// looped_iir_pkg -- shared state type and helpers for the looped IIR sequencer
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package looped_iir_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RECOVER = 2'd2
  } state_e;

  localparam int SRST_CYCLES = 2;

  // Core latency is NSECTIONS+1; the margin covers pipeline slack around it.
  function automatic int default_timeout(input int nsections);
    return nsections + 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/filters_sync_fifo.sv
// ----------------------------------------------------------------------------
// filters_sync_fifo -- register-based synchronous FIFO with occupancy count
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module filters_sync_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   arstn_i,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          din,
  output logic [DW-1:0]          dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int              AW        = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE   = AW'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (fill == DEPTH_CNT);
  assign empty   = (fill == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   fill <= fill + CNT_ONE;
        2'b01:   fill <= fill - CNT_ONE;
        default: fill <= fill;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/looped_iir_sequencer.sv
// ----------------------------------------------------------------------------
// looped_iir_sequencer -- stream front/back end and watchdog for the looped IIR core
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module looped_iir_sequencer
  import looped_iir_pkg::*;
#(
  parameter int DW         = 16,
  parameter int NSECTIONS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = default_timeout(NSECTIONS)
) (
  input  logic                          clk_i,
  input  logic                          arstn_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [DW-1:0]                 s_data_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [DW-1:0]                 m_data_o,
  output logic                          flt_start_o,
  output logic [DW-1:0]                 flt_data_o,
  output logic                          flt_srst_o,
  input  logic [DW-1:0]                 flt_data_i,
  input  logic                          flt_valid_i,
  output logic                          timeout_o,
  output logic [$clog2(FIFO_DEPTH):0]   fill_o
);

  localparam int              WDW       = $clog2(TIMEOUT);
  localparam logic [WDW-1:0]  WD_LAST   = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0]  WD_ONE    = WDW'(1);
  localparam int              SCW       = (SRST_CYCLES > 1) ? $clog2(SRST_CYCLES) : 1;
  localparam logic [SCW-1:0]  SRST_LAST = SCW'(SRST_CYCLES - 1);
  localparam logic [SCW-1:0]  SRST_ONE  = SCW'(1);

  state_e         state, state_nxt;
  logic [WDW-1:0] wd_cnt, wd_nxt;
  logic [SCW-1:0] srst_cnt, srst_cnt_nxt;
  logic           m_valid_nxt;
  logic [DW-1:0]  m_data_nxt;
  logic           start_nxt;
  logic [DW-1:0]  flt_data_nxt;
  logic           srst_nxt;
  logic           timeout_nxt;

  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_pop;
  logic [DW-1:0]  fifo_head;

  assign s_ready_o = !fifo_full;

  filters_sync_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .push    (s_valid_i && s_ready_o),
    .pop     (fifo_pop),
    .din     (s_data_i),
    .dout    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .fill    (fill_o)
  );

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state       <= IDLE;
      wd_cnt      <= '0;
      srst_cnt    <= '0;
      m_valid_o   <= 1'b0;
      m_data_o    <= '0;
      flt_start_o <= 1'b0;
      flt_data_o  <= '0;
      flt_srst_o  <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      state       <= state_nxt;
      wd_cnt      <= wd_nxt;
      srst_cnt    <= srst_cnt_nxt;
      m_valid_o   <= m_valid_nxt;
      m_data_o    <= m_data_nxt;
      flt_start_o <= start_nxt;
      flt_data_o  <= flt_data_nxt;
      flt_srst_o  <= srst_nxt;
      timeout_o   <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wd_nxt       = wd_cnt;
    srst_cnt_nxt = srst_cnt;
    m_valid_nxt  = m_valid_o && !m_ready_i;
    m_data_nxt   = m_data_o;
    start_nxt    = 1'b0;
    flt_data_nxt = flt_data_o;
    srst_nxt     = 1'b0;
    timeout_nxt  = timeout_o;
    fifo_pop     = 1'b0;
    case (state)
      IDLE: begin
        // Holding off while a result is pending keeps the result register safe.
        if (!fifo_empty && !m_valid_o) begin
          fifo_pop     = 1'b1;
          flt_data_nxt = fifo_head;
          start_nxt    = 1'b1;
          wd_nxt       = '0;
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        if (flt_valid_i) begin
          m_data_nxt  = flt_data_i;
          m_valid_nxt = 1'b1;
          state_nxt   = IDLE;
        end else if (wd_cnt == WD_LAST) begin
          srst_nxt     = 1'b1;
          srst_cnt_nxt = '0;
          timeout_nxt  = 1'b1;
          state_nxt    = RECOVER;
        end else begin
          wd_nxt = wd_cnt + WD_ONE;
        end
      end
      RECOVER: begin
        if (srst_cnt == SRST_LAST) begin
          state_nxt = IDLE;
        end else begin
          srst_nxt     = 1'b1;
          srst_cnt_nxt = srst_cnt + SRST_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_looped_iir_sequencer.sv
// ----------------------------------------------------------------------------
// tb_looped_iir_sequencer -- randomized bench with core model and output scoreboard
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_looped_iir_sequencer;

  localparam int DW        = 16;
  localparam int NSECTIONS = 8;
  localparam int DEPTH     = 4;
  localparam int TIMEOUT   = 16;

  logic          clk = 1'b0;
  logic          arstn;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          flt_start;
  logic [DW-1:0] flt_dout;
  logic          flt_srst;
  logic [DW-1:0] flt_din;
  logic          flt_valid;
  logic          timeout;
  logic [2:0]    fill;

  always #5 clk = ~clk;

  looped_iir_sequencer #(
    .DW         (DW),
    .NSECTIONS  (NSECTIONS),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_i       (clk),
    .arstn_i     (arstn),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .s_data_i    (s_data),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .m_data_o    (m_data),
    .flt_start_o (flt_start),
    .flt_data_o  (flt_dout),
    .flt_srst_o  (flt_srst),
    .flt_data_i  (flt_din),
    .flt_valid_i (flt_valid),
    .timeout_o   (timeout),
    .fill_o      (fill)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: accepted samples in order, expected results in order.
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pend_result;
  int  core_lat    = NSECTIONS + 1;
  bit  rand_lat    = 1'b0;
  bit  rand_ready  = 1'b0;
  bit  core_active = 1'b0;
  int  core_cnt    = 0;
  int  drop_cnt    = 0;
  bit  spurious    = 1'b0;
  int  starts      = 0;
  int  outputs     = 0;
  int  dropped     = 0;
  int  cyc         = 0;
  int  last_start  = 0;
  int  srst_delay  = 0;
  int  srst_len    = 0;
  int  srst_run    = 0;
  bit  full_seen   = 1'b0;
  int  ready_when_full = 0;

  // Core model: returns sample+1 a fixed or random number of cycles after start.
  initial begin
    flt_valid = 1'b0;
    flt_din   = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      flt_valid = 1'b0;
      if (!arstn || flt_srst) core_active = 1'b0;
      if (spurious) begin
        flt_valid = 1'b1;
        flt_din   = DW'($urandom);
        spurious  = 1'b0;
      end else if (core_active) begin
        core_cnt--;
        if (core_cnt == 0) begin
          flt_valid   = 1'b1;
          flt_din     = pend_result;
          core_active = 1'b0;
        end
      end
      if (flt_start) begin
        starts++;
        check("start_while_busy", 32'(core_active), 32'(0));
        check("start_with_result_pending", 32'(m_valid), 32'(0));
        if (in_q.size() == 0) check("start_unexpected", 32'(1), 32'(0));
        else check("core_in_data", 32'(flt_dout), 32'(in_q.pop_front()));
        if (drop_cnt > 0) begin
          drop_cnt--;
          dropped++;
        end else begin
          pend_result = flt_dout + DW'(1);
          exp_q.push_back(pend_result);
          core_active = 1'b1;
          core_cnt    = rand_lat ? int'($urandom_range(1, 12)) : core_lat;
        end
      end
    end
  end

  // Monitor: stream handshakes, occupancy and recovery-pulse timing.
  initial begin
    forever begin
      @(negedge clk);
      if (s_valid && s_ready) in_q.push_back(s_data);
      if (m_valid && m_ready) begin
        outputs++;
        if (exp_q.size() == 0) check("output_unexpected", 32'(1), 32'(0));
        else check("output_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      if (fill == 3'(DEPTH)) begin
        full_seen = 1'b1;
        if (s_ready) ready_when_full++;
      end
      if (flt_srst) begin
        srst_run++;
        if (srst_run == 1) srst_delay = cyc - last_start;
      end else if (srst_run != 0) begin
        srst_len = srst_run;
        srst_run = 0;
      end
      if (flt_start) last_start = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input logic [DW-1:0] d);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("push_timeout", 32'(1), 32'(0));
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (!(in_q.size() == 0 && exp_q.size() == 0 && !core_active &&
             fill == 3'd0 && !m_valid) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check("drain_timeout", 32'(1), 32'(0));
    repeat (4) step();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ctrl"}, 32'({s_ready, m_valid, flt_start, flt_srst, timeout}), 32'(5'b10000));
    check({tag, "_m_data"}, 32'(m_data), 32'(0));
    check({tag, "_flt_data"}, 32'(flt_dout), 32'(0));
    check({tag, "_fill"}, 32'(fill), 32'(0));
  endtask

  initial begin
    int n;
    int s0;
    int o0;
    int d0;
    logic [DW-1:0] held;
    arstn   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    arstn = 1'b1;
    step();
    step();

    // Single sample with latency measurement from acceptance edge.
    s0 = starts;
    o0 = outputs;
    s_valid = 1'b1;
    s_data  = 16'h1000;
    step();
    s_valid = 1'b0;
    n = 0;
    while (!m_valid && n < 100) begin
      step();
      n++;
    end
    check("single_latency", 32'(n), 32'(11));
    check("single_data", 32'(m_data), 32'(16'h1001));
    wait_drain(100);
    check("single_starts", 32'(starts - s0), 32'(1));
    check("single_outputs", 32'(outputs - o0), 32'(1));

    // Burst of six into a four-deep FIFO.
    full_seen = 1'b0;
    ready_when_full = 0;
    o0 = outputs;
    for (int i = 0; i < 6; i++) push(DW'($urandom));
    wait_drain(500);
    check("burst_full_seen", 32'(full_seen), 32'(1));
    check("burst_ready_when_full", 32'(ready_when_full), 32'(0));
    check("burst_outputs", 32'(outputs - o0), 32'(6));

    // Backpressure: result held, no new start, FIFO fills up.
    m_ready = 1'b0;
    o0 = outputs;
    for (int i = 0; i < 5; i++) push(DW'($urandom));
    n = 0;
    while (!m_valid && n < 100) begin
      step();
      n++;
    end
    held = m_data;
    s0 = starts;
    repeat (50) step();
    check("bp_data_stable", 32'(m_data), 32'(held));
    check("bp_valid_held", 32'(m_valid), 32'(1));
    check("bp_no_start", 32'(starts - s0), 32'(0));
    check("bp_fill", 32'(fill), 32'(DEPTH));
    check("bp_ready_low", 32'(s_ready), 32'(0));
    m_ready = 1'b1;
    wait_drain(500);
    check("bp_outputs", 32'(outputs - o0), 32'(5));

    // Result arriving in the very cycle the watchdog expires.
    o0 = outputs;
    core_lat = TIMEOUT - 1;
    push(16'h4444);
    wait_drain(200);
    core_lat = NSECTIONS + 1;
    check("expiry_edge_output", 32'(outputs - o0), 32'(1));
    check("expiry_edge_no_timeout", 32'(timeout), 32'(0));

    // Spurious core valid while idle.
    o0 = outputs;
    spurious = 1'b1;
    repeat (5) step();
    check("spurious_no_output", 32'(outputs - o0), 32'(0));
    check("spurious_m_valid", 32'(m_valid), 32'(0));

    // Watchdog: first sample never answered, second proceeds normally.
    o0 = outputs;
    d0 = dropped;
    srst_len = 0;
    drop_cnt = 1;
    push(16'h5555);
    push(16'h6666);
    wait_drain(300);
    check("wd_dropped", 32'(dropped - d0), 32'(1));
    check("wd_srst_delay", 32'(srst_delay), 32'(TIMEOUT));
    check("wd_srst_len", 32'(srst_len), 32'(2));
    check("wd_timeout_sticky", 32'(timeout), 32'(1));
    check("wd_outputs", 32'(outputs - o0), 32'(1));

    // Randomized traffic with random core latency, backpressure and drops.
    rand_ready = 1'b1;
    rand_lat   = 1'b1;
    o0 = outputs;
    d0 = dropped;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) step();
      if ($urandom_range(0, 7) == 0) drop_cnt = 1;
      push(DW'($urandom));
    end
    wait_drain(3000);
    rand_ready = 1'b0;
    rand_lat   = 1'b0;
    drop_cnt   = 0;
    m_ready    = 1'b1;
    repeat (TIMEOUT + 4) step();
    check("rand_outputs", 32'(outputs - o0), 32'(40 - (dropped - d0)));
    check("rand_timeout_sticky", 32'(timeout), 32'(1));

    // Asynchronous reset in the middle of a BUSY window.
    push(16'h7000);
    n = 0;
    while (!core_active && n < 50) begin
      step();
      n++;
    end
    repeat (3) step();
    #2;
    arstn = 1'b0;
    #1;
    check_reset_values("midreset");
    in_q.delete();
    exp_q.delete();
    core_active = 1'b0;
    #2;
    arstn = 1'b1;
    step();
    o0 = outputs;
    push(16'h7abc);
    wait_drain(200);
    check("post_reset_outputs", 32'(outputs - o0), 32'(1));
    check("post_reset_timeout", 32'(timeout), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
